// File: rtl/cache_ctrl.sv
// cache_ctrl: 4-way set-associative, write-through, no-write-allocate cache controller.
// Keeps the tag/valid/tree-PLRU state and drives the data array and the RAM handshake.
//
// Ports:
//   clk, gen_reset                     clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request (held until cpu_ready)
//   cpu_rdata/cpu_ready                read data and one-cycle completion pulse
//   write_enable[3:0]                  one-hot way select to the array
//   write_enable_cpu[1:0]              CPU write strobe (2'b11 = full word)
//   write_enable_ram                   fill-from-RAM strobe
//   read_enable/adress/data_in         array read enable, address and write data
//   data_out1..data_out4               per-way array read data, valid the cycle after read_enable
//   ram_req/ram_we/ram_addr/ram_wdata  RAM request, held until ram_ack
//   ram_rdata/ram_ack                  RAM read data and one-cycle completion
//   hit_count/miss_count               saturating request counters, only with CACHE_CTRL_STATS_EN
//
// Optional feature macro: CACHE_CTRL_STATS_EN.
module cache_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned INDEX_W = 4
) (
    input  logic              clk,
    input  logic              gen_reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic [3:0]        write_enable,
    output logic [1:0]        write_enable_cpu,
    output logic              write_enable_ram,
    output logic              read_enable,
    output logic [ADDR_W-1:0] adress,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out1,
    input  logic [DATA_W-1:0] data_out2,
    input  logic [DATA_W-1:0] data_out3,
    input  logic [DATA_W-1:0] data_out4,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W;
    localparam int unsigned SETS  = 2 ** INDEX_W;

    typedef enum logic [1:0] {StIdle, StLookup, StFillWait, StWriteThru} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          victim_q, victim_d;

    logic [TAG_W-1:0]    tag_q   [SETS][4];
    logic [3:0]          valid_q [SETS];
    logic [2:0]          plru_q  [SETS];

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic [3:0]          hit_vec;
    logic                hit;
    logic [1:0]          hit_way;
    logic [1:0]          victim_way;
    logic [DATA_W-1:0]   rd [4];

    logic                lat_en;
    logic                fill_en;
    logic                plru_upd;
    logic [1:0]          upd_way;

    // Tree PLRU: bit0 = victim in upper half, bit1 = victim is way1, bit2 = victim is way3.
    // An access points every bit on its path away from the accessed way.
    function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] r;
        r    = b;
        r[0] = ~w[1];
        if (w[1]) r[2] = ~w[0];
        else      r[1] = ~w[0];
        return r;
    endfunction

    function automatic logic [1:0] plru_victim(input logic [2:0] b);
        return {b[0], b[0] ? b[2] : b[1]};
    endfunction

    assign rd[0] = data_out1;
    assign rd[1] = data_out2;
    assign rd[2] = data_out3;
    assign rd[3] = data_out4;

    assign idx = addr_q[INDEX_W-1:0];
    assign tag = addr_q[ADDR_W-1:INDEX_W];

    always_comb begin
        for (int w = 0; w < 4; w++) begin
            hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
        end
        hit     = |hit_vec;
        hit_way = {hit_vec[3] | hit_vec[2], hit_vec[3] | hit_vec[1]};
    end

    // Lowest-numbered invalid way wins; PLRU only decides when the set is full.
    always_comb begin
        victim_way = plru_victim(plru_q[idx]);
        for (int w = 3; w >= 0; w--) begin
            if (!valid_q[idx][w]) victim_way = 2'(w);
        end
    end

    always_comb begin
        state_d          = state_q;
        victim_d         = victim_q;
        cpu_rdata        = '0;
        cpu_ready        = 1'b0;
        write_enable     = '0;
        write_enable_cpu = '0;
        write_enable_ram = 1'b0;
        read_enable      = 1'b0;
        adress           = '0;
        data_in          = '0;
        ram_req          = 1'b0;
        ram_we           = 1'b0;
        ram_addr         = '0;
        ram_wdata        = '0;
        lat_en           = 1'b0;
        fill_en          = 1'b0;
        plru_upd         = 1'b0;
        upd_way          = hit_way;
        // Outputs are forced quiet while reset is held so an abort never leaks a strobe.
        if (!gen_reset) begin
            unique case (state_q)
                StIdle: begin
                    if (cpu_req) begin
                        read_enable = 1'b1;
                        adress      = cpu_addr;
                        lat_en      = 1'b1;
                        state_d     = StLookup;
                    end
                end
                StLookup: begin
                    if (hit) begin
                        plru_upd = 1'b1;
                        if (we_q) begin
                            write_enable     = 4'b0001 << hit_way;
                            write_enable_cpu = 2'b11;
                            adress           = addr_q;
                            data_in          = wdata_q;
                            state_d          = StWriteThru;
                        end else begin
                            cpu_rdata = rd[hit_way];
                            cpu_ready = 1'b1;
                            state_d   = StIdle;
                        end
                    end else if (we_q) begin
                        state_d = StWriteThru;
                    end else begin
                        victim_d = victim_way;
                        state_d  = StFillWait;
                    end
                end
                StFillWait: begin
                    ram_req  = 1'b1;
                    ram_addr = addr_q;
                    if (ram_ack) begin
                        write_enable     = 4'b0001 << victim_q;
                        write_enable_ram = 1'b1;
                        adress           = addr_q;
                        data_in          = ram_rdata;
                        cpu_rdata        = ram_rdata;
                        cpu_ready        = 1'b1;
                        fill_en          = 1'b1;
                        plru_upd         = 1'b1;
                        upd_way          = victim_q;
                        state_d          = StIdle;
                    end
                end
                StWriteThru: begin
                    ram_req   = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = addr_q;
                    ram_wdata = wdata_q;
                    if (ram_ack) begin
                        cpu_ready = 1'b1;
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (gen_reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (lat_en) begin
                addr_q  <= cpu_addr;
                we_q    <= cpu_we;
                wdata_q <= cpu_wdata;
            end
            if (fill_en) valid_q[idx][victim_q] <= 1'b1;
            if (plru_upd) plru_q[idx] <= plru_touch(plru_q[idx], upd_way);
        end
    end

    // Tags need no reset: they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (fill_en) tag_q[idx][victim_q] <= tag;
    end

`ifdef CACHE_CTRL_STATS_EN
    logic wt_hit_q;
    logic req_hit, req_miss;

    always_comb begin
        req_hit  = (state_q == StLookup && hit && !we_q) ||
                   (state_q == StWriteThru && ram_ack && wt_hit_q);
        req_miss = (state_q == StFillWait && ram_ack) ||
                   (state_q == StWriteThru && ram_ack && !wt_hit_q);
    end

    always_ff @(posedge clk) begin
        if (gen_reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            wt_hit_q   <= 1'b0;
        end else begin
            if (state_q == StLookup) wt_hit_q <= hit;
            if (req_hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            if (req_miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: a driver issues requests and pushes the response predicted by
// a behavioural cache model; a negedge monitor pops and compares whenever cpu_ready pulses.
// The bench also emulates the data array and a variable-latency RAM.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        gen_reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [63:0] cpu_wdata = '0;
    logic [63:0] cpu_rdata;
    logic        cpu_ready;
    logic [3:0]  write_enable;
    logic [1:0]  write_enable_cpu;
    logic        write_enable_ram;
    logic        read_enable;
    logic [9:0]  adress;
    logic [63:0] data_in;
    logic [63:0] data_out1, data_out2, data_out3, data_out4;
    logic        ram_req;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata = '0;
    logic        ram_ack = 1'b0;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk              (clk),
        .gen_reset        (gen_reset),
        .cpu_req          (cpu_req),
        .cpu_we           (cpu_we),
        .cpu_addr         (cpu_addr),
        .cpu_wdata        (cpu_wdata),
        .cpu_rdata        (cpu_rdata),
        .cpu_ready        (cpu_ready),
        .write_enable     (write_enable),
        .write_enable_cpu (write_enable_cpu),
        .write_enable_ram (write_enable_ram),
        .read_enable      (read_enable),
        .adress           (adress),
        .data_in          (data_in),
        .data_out1        (data_out1),
        .data_out2        (data_out2),
        .data_out3        (data_out3),
        .data_out4        (data_out4),
        .ram_req          (ram_req),
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .ram_rdata        (ram_rdata),
        .ram_ack          (ram_ack)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .hit_count        (hit_count),
        .miss_count       (miss_count)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Power-on RAM contents; address 1 holds 15.
    function automatic logic [63:0] init_val(input logic [9:0] a);
        return 64'(a) * 64'd7 + 64'd8;
    endfunction

    // ---------------- data array emulation ----------------
    logic [63:0] arr  [4][16];
    logic [63:0] dout [4];
    always @(posedge clk) begin
        if (read_enable) begin
            for (int w = 0; w < 4; w++) dout[w] <= arr[w][adress[3:0]];
        end
        for (int w = 0; w < 4; w++) begin
            if (write_enable[w] && (write_enable_ram || write_enable_cpu == 2'b11))
                arr[w][adress[3:0]] <= data_in;
        end
    end
    assign data_out1 = dout[0];
    assign data_out2 = dout[1];
    assign data_out3 = dout[2];
    assign data_out4 = dout[3];

    // ---------------- RAM emulation ----------------
    logic [63:0] ram_mem [1024];
    bit          ram_wr  [1024];
    bit          hold_ack = 1'b0;
    int          ram_wait = 0;
    int          ram_lat = 1;
    always @(posedge clk) begin
        if (gen_reset) begin
            ram_ack  <= 1'b0;
            ram_wait <= 0;
        end else if (ram_ack) begin
            ram_ack <= 1'b0;
        end else if (ram_req && !hold_ack) begin
            if (ram_wait >= ram_lat) begin
                ram_ack  <= 1'b1;
                ram_wait <= 0;
                ram_lat  <= int'($urandom_range(0, 3));
                if (ram_we) begin
                    ram_mem[ram_addr] <= ram_wdata;
                    ram_wr[ram_addr]  <= 1'b1;
                end else begin
                    ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_val(ram_addr);
                end
            end else begin
                ram_wait <= ram_wait + 1;
            end
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        is_read;
        logic        hit;
        logic [1:0]  way;
        logic [9:0]  addr;
        logic [63:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] m_mem [int];
    logic [5:0]  m_tag [16][4];
    bit          m_val [16][4];
    // Pseudo-LRU expressed as "which half is older" and "which way inside each half is older".
    bit          m_old_upper [16];
    bit          m_old_l [16];
    bit          m_old_r [16];
    int          m_hits = 0;
    int          m_misses = 0;

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_old_upper[s] = 0;
            m_old_l[s] = 0;
            m_old_r[s] = 0;
            for (int w = 0; w < 4; w++) m_val[s][w] = 0;
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic model_touch(input int s, input int w);
        m_old_upper[s] = (w < 2);
        if (w < 2) m_old_l[s] = (w == 0);
        else       m_old_r[s] = (w == 2);
    endtask

    task automatic model_req(input bit we, input logic [9:0] a, input logic [63:0] wd,
                             output exp_t e);
        int s;
        int hw;
        int v;
        s  = int'(a) % 16;
        hw = -1;
        for (int w = 0; w < 4; w++) if (m_val[s][w] && m_tag[s][w] == a[9:4]) hw = w;
        e.is_read = !we;
        e.addr    = a;
        e.hit     = (hw >= 0);
        e.way     = 2'(hw);
        if (hw >= 0) m_hits++;
        else         m_misses++;
        if (!we) begin
            e.data = m_mem.exists(int'(a)) ? m_mem[int'(a)] : init_val(a);
            if (hw >= 0) begin
                model_touch(s, hw);
            end else begin
                v = -1;
                for (int w = 3; w >= 0; w--) if (!m_val[s][w]) v = w;
                if (v < 0) v = m_old_upper[s] ? 2 + int'(m_old_r[s]) : int'(m_old_l[s]);
                m_val[s][v] = 1;
                m_tag[s][v] = a[9:4];
                e.way = 2'(v);
                model_touch(s, v);
            end
        end else begin
            e.data = wd;
            m_mem[int'(a)] = wd;
            if (hw >= 0) model_touch(s, hw);
        end
    endtask

    // ---------------- monitor ----------------
    bit          busy = 0;
    int          cyc = 0;
    int          we_pulses = 0;
    logic [3:0]  we_val;
    logic [2:0]  we_strb;
    logic [63:0] we_data;
    logic [9:0]  we_addr;
    bit          ram_seen;
    logic        r_we;
    logic [9:0]  r_addr;
    logic [63:0] r_wdata;
    logic [3:0]  last_we = '0;
    bit          last_ram = 0;

    initial begin
        exp_t       e;
        logic [3:0] oh;
        forever begin
            @(negedge clk);
            if (gen_reset) begin
                busy = 0;
            end else begin
                if (busy) cyc++;
                if (!busy && cpu_req) begin
                    busy = 1;
                    cyc = 1;
                    we_pulses = 0;
                    we_val = '0;
                    ram_seen = 0;
                    chk("accept_read_enable", 64'(read_enable), 64'd1);
                    chk("accept_adress", 64'(adress), 64'(cpu_addr));
                end
                if (write_enable != '0) begin
                    we_pulses++;
                    we_val  = write_enable;
                    we_strb = {write_enable_ram, write_enable_cpu};
                    we_data = data_in;
                    we_addr = adress;
                end
                if (ram_req && ram_ack) begin
                    ram_seen = 1;
                    r_we     = ram_we;
                    r_addr   = ram_addr;
                    r_wdata  = ram_wdata;
                end
                if (cpu_ready) begin
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_ready: cpu_ready with nothing outstanding");
                    end else begin
                        e  = sb_q.pop_front();
                        oh = 4'b0001 << e.way;
                        if (e.is_read) begin
                            chk("rdata", cpu_rdata, e.data);
                            if (e.hit) begin
                                chk("rd_hit_latency", 64'(cyc), 64'd2);
                                chk("rd_hit_no_ram", 64'(ram_seen), 64'd0);
                                chk("rd_hit_no_we", 64'(we_pulses), 64'd0);
                            end else begin
                                chk("fill_ram_seen", 64'(ram_seen), 64'd1);
                                chk("fill_ram_we", 64'(r_we), 64'd0);
                                chk("fill_ram_addr", 64'(r_addr), 64'(e.addr));
                                chk("fill_pulses", 64'(we_pulses), 64'd1);
                                chk("fill_way", 64'(we_val), 64'(oh));
                                chk("fill_strobe", 64'(we_strb), 64'b100);
                                chk("fill_data", we_data, e.data);
                                chk("fill_adress", 64'(we_addr), 64'(e.addr));
                            end
                        end else begin
                            chk("wt_ram_seen", 64'(ram_seen), 64'd1);
                            chk("wt_ram_we", 64'(r_we), 64'd1);
                            chk("wt_ram_addr", 64'(r_addr), 64'(e.addr));
                            chk("wt_ram_wdata", r_wdata, e.data);
                            if (e.hit) begin
                                chk("wr_hit_pulses", 64'(we_pulses), 64'd1);
                                chk("wr_hit_way", 64'(we_val), 64'(oh));
                                chk("wr_hit_strobe", 64'(we_strb), 64'b011);
                                chk("wr_hit_data", we_data, e.data);
                            end else begin
                                chk("wr_miss_no_we", 64'(we_pulses), 64'd0);
                            end
                        end
                    end
                    last_we  = we_val;
                    last_ram = ram_seen;
                    busy = 0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input bit we, input logic [9:0] a, input logic [63:0] wd);
        exp_t e;
        bit   got;
        model_req(we, a, wd, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = wd;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            #1;
            if (cpu_ready) got = 1;
        end
        cpu_req = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: addr %0h got no cpu_ready, required within 40 cycles", a);
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_ctl"}, 64'({cpu_ready, write_enable, write_enable_cpu, write_enable_ram,
                               read_enable, ram_req, ram_we}), 64'd0);
        chk({nm, "_bus"}, 64'(|{cpu_rdata, adress, data_in, ram_addr, ram_wdata}), 64'd0);
    endtask

    initial begin
        exp_t e;
        bit   got;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset_held");
        @(posedge clk);
        #1 gen_reset = 1'b0;
        @(negedge clk);
        chk_quiet("reset_idle");
`ifdef CACHE_CTRL_STATS_EN
        chk("reset_hit_count", 64'(hit_count), 64'd0);
        chk("reset_miss_count", 64'(miss_count), 64'd0);
`endif

        // Directed sequence from the plan.
        issue(0, 10'h001, '0);
        chk("first_fill_way0", 64'(last_we), 64'b0001);
        issue(0, 10'h001, '0);
        chk("second_read_no_ram", 64'(last_ram), 64'd0);
        issue(0, 10'h011, '0);
        chk("fill_way1", 64'(last_we), 64'b0010);
        issue(0, 10'h021, '0);
        chk("fill_way2", 64'(last_we), 64'b0100);
        issue(0, 10'h031, '0);
        chk("fill_way3", 64'(last_we), 64'b1000);
        issue(0, 10'h041, '0);
        chk("plru_victim_way0", 64'(last_we), 64'b0001);
        issue(1, 10'h001, 64'd25);
        chk("wr_miss_no_array_write", 64'(last_we), 64'd0);
        issue(1, 10'h011, 64'd80);
        chk("wr_hit_way1", 64'(last_we), 64'b0010);
        issue(0, 10'h011, '0);

        // Abort a fill with reset while the RAM withholds its ack.
        hold_ack = 1'b1;
        model_req(0, 10'h051, '0, e);
        @(posedge clk);
        #1;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 10'h051;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            #1;
            if (ram_req) got = 1;
        end
        chk("abort_fill_reached", 64'(got), 64'd1);
        gen_reset = 1'b1;
        cpu_req = 1'b0;
        #1 chk_quiet("abort_reset_cycle");
        @(negedge clk);
        #1 chk_quiet("abort_reset_held");
        @(posedge clk);
        #1;
        gen_reset = 1'b0;
        hold_ack = 1'b0;
        model_reset();
        @(negedge clk);
        #1 chk_quiet("abort_after");
`ifdef CACHE_CTRL_STATS_EN
        chk("abort_hit_count", 64'(hit_count), 64'd0);
        chk("abort_miss_count", 64'(miss_count), 64'd0);
`endif
        issue(0, 10'h051, '0);
        chk("reread_misses", 64'(last_ram), 64'd1);

        // Random traffic over a few sets and tags to force hits, fills and evictions.
        for (int n = 0; n < 400; n++) begin
            logic [9:0]  a;
            logic [63:0] wd;
            a  = 10'(($urandom_range(0, 5) << 4) | $urandom_range(0, 2));
            wd = {$urandom, $urandom};
            issue($urandom_range(0, 2) == 0, a, wd);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
`ifdef CACHE_CTRL_STATS_EN
        chk("final_hit_count", 64'(hit_count), 64'(m_hits > 65535 ? 65535 : m_hits));
        chk("final_miss_count", 64'(miss_count), 64'(m_misses > 65535 ? 65535 : m_misses));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- 4-way set-associative cache controller that sits directly upstream of the cache data array.
- Accepts single-word CPU read/write requests and performs the tag lookup internally (tag and valid arrays).
- Drives the array's per-way write enables, its RAM-fill and CPU-write strobes, and its address and data buses.
- Fetches missing lines from RAM through a request/acknowledge handshake. Write-through, no-write-allocate.

Parameters:
- ADDR_W, 10, CPU/RAM word address width.
- DATA_W, 64, data word width; one word per line.
- INDEX_W, 4, set index bits (addr[INDEX_W-1:0]); tag = addr[ADDR_W-1:INDEX_W], 6 bits by default.

Ports:
- clk  in  1  clock; all logic on rising edge.
- gen_reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  request valid; held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  request address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data, valid when cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- write_enable  out  4  one-hot way select to the array.
- write_enable_cpu  out  2  CPU write strobe to the array; 2'b11 = full-word write.
- write_enable_ram  out  1  fill-from-RAM strobe to the array.
- read_enable  out  1  array read enable.
- adress  out  ADDR_W  array address.
- data_in  out  DATA_W  array write data.
- data_out1..data_out4  in  DATA_W each  per-way array read data; valid the cycle after read_enable.
- ram_req  out  1  RAM request, held until ram_ack.
- ram_we  out  1  RAM write (1) / read (0).
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid with ram_ack.
- ram_ack  in  1  one-cycle RAM completion.

Behaviour:
- Reset: all valid bits and PLRU bits = 0; state = IDLE. All outputs = 0.
- Reset mid-operation aborts any transaction with no cpu_ready; the CPU must re-issue the request.
- IDLE:
  - On cpu_req, latch addr, we and wdata.
  - Drive read_enable=1 and adress=addr.
  - Go to LOOKUP.
- LOOKUP:
  - Compare the latched tag against the 4 ways of the indexed set.
  - A hit requires valid=1 and a tag match. Multiple matches cannot occur by construction.
- Read hit:
  - cpu_rdata = data_outN of the hit way; pulse cpu_ready in the same cycle.
  - Update PLRU toward the hit way; return to IDLE.
  - Latency: cpu_ready 2 cycles after cpu_req is sampled.
- Read miss:
  - Go to FILL_WAIT with ram_req=1, ram_we=0, ram_addr=addr.
  - Victim = lowest-numbered invalid way; if all 4 ways are valid, the tree-PLRU victim (3 bits per set).
- FILL_WAIT, on ram_ack, for exactly 1 cycle:
  - write_enable = one-hot victim, write_enable_ram=1, data_in=ram_rdata.
  - Set the victim's tag and valid bit.
  - cpu_rdata=ram_rdata; pulse cpu_ready.
  - Update PLRU; go to IDLE.
- Write hit:
  - Same cycle: write_enable = hit way, write_enable_cpu=2'b11, data_in=wdata; PLRU updated.
  - Then WRITE_THRU: ram_req=1, ram_we=1, ram_wdata=wdata.
  - On ram_ack: pulse cpu_ready, go to IDLE.
- Write miss: straight to WRITE_THRU; the array and tags are untouched.
- ram_req and its address/data stay stable until ram_ack. A ram_ack arriving outside a RAM wait state is ignored.
- cpu_req is not sampled while busy. A new request is accepted in the IDLE cycle after cpu_ready at the earliest.
- Strobes (write_enable*, write_enable_ram, cpu_ready) are single-cycle pulses; otherwise 0.

Optional Feature:
- Macro: CACHE_CTRL_STATS_EN.
- Defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - Each increments once per completed request (reads and writes).
  - Both saturate at 16'hFFFF and clear on gen_reset.
- Undefined: the ports and counters do not exist.

Test Plan:
- Read 0x001 after reset:
  - Miss → ram_req with ram_addr=0x001, ram_we=0.
  - ram_ack with rdata=15 → write_enable=4'b0001, write_enable_ram=1, cpu_rdata=15, cpu_ready.
- Read 0x001 again:
  - Hit in way 0, no ram_req.
  - cpu_ready exactly 2 cycles after the req sample; cpu_rdata = data_out1.
- Fill 0x011, 0x021, 0x031 (same set 1) → ways 1, 2, 3 in order.
  - Then read 0x041 → victim = PLRU way (0 after that access order); write_enable=4'b0001.
- Write 0x001 data 25 after 0x041 evicted it:
  - Miss: ram_we=1, ram_wdata=25.
  - No write_enable pulse; cpu_ready after ram_ack.
- Write hit 0x011 data 80:
  - write_enable=4'b0010, write_enable_cpu=2'b11, data_in=80.
  - Then RAM write; a read of 0x011 returns 80.
- Assert gen_reset during FILL_WAIT:
  - No cpu_ready, all outputs 0.
  - A re-read of the same address misses again.
  - With CACHE_CTRL_STATS_EN defined: counters read 0.
